rd_port_arbiter: RTL and testbench
==================================

RD_PORT_ARBITER -- requirements
Module: rd_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM read-data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 1, RAM read-address width; slot count = 2^ADDR_WIDTH.
REQ-003 SHALL have port r_clk  in  1  read-domain clock; all logic on rising edge.
REQ-004 SHALL have port n_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0, req1  in  1  one-cycle request pulses (already edge-detected) from requesters 0 and 1.
REQ-006 SHALL have ports addr0, addr1  in  ADDR_WIDTH  slot address, sampled in the same cycle as its req.
REQ-007 SHALL have port status_vld  in  2^ADDR_WIDTH  per-slot "slot holds unread data" flags from the write controller.
REQ-008 SHALL have port ram_rdaddr  out  ADDR_WIDTH  registered read address to the dual-port RAM.
REQ-009 SHALL have port ram_q  in  DATA_WIDTH  RAM read data, valid one r_clk edge after the RAM samples ram_rdaddr.
REQ-010 SHALL have ports gnt0, gnt1  out  1  one-cycle grant pulses.
REQ-011 SHALL have port rdata  out  DATA_WIDTH  registered read data, shared by both requesters.
REQ-012 SHALL have ports rvld0, rvld1  out  1  one-cycle pulses: rdata valid for that requester.
REQ-013 SHALL have ports rerr0, rerr1  out  1  one-cycle pulses: request addressed an empty slot.
REQ-014 SHALL have port r_done  out  2^ADDR_WIDTH  one-cycle pulse on the bit of the slot just consumed.
REQ-015 SHALL have port busy  out  1  high whenever FSM is not IDLE.

Function
REQ-016 SHALL capture each req pulse into a pending flag plus latched address; a req arriving while its pending flag is already set SHALL be dropped (address unchanged).
REQ-017 SHALL, if a requester's pending flag is cleared by a grant in the same cycle its new req arrives, leave the pending flag set with the new address.
REQ-018 SHALL implement FSM states IDLE, ADDR, WAIT, RESP, ERR.
REQ-019 IDLE: with any pending flag set, SHALL select a winner, clear its pending flag, pulse its gnt in the next cycle, register owner and ram_rdaddr, then go to ADDR if status_vld[addr]=1, else ERR.
REQ-020 SHALL arbitrate round-robin: when both pending, the requester not granted last wins; a single pending requester always wins.
REQ-021 ADDR -> WAIT unconditionally (RAM samples ram_rdaddr at this edge).
REQ-022 WAIT -> RESP; at this edge rdata <= ram_q.
REQ-023 RESP: SHALL pulse rvld of owner and r_done[ram_rdaddr] for exactly one cycle, then return to IDLE.
REQ-024 ERR: SHALL pulse rerr of owner for one cycle, leave rdata unchanged, issue no r_done, return to IDLE.
REQ-025 Latency: req pulse sampled at edge E0, uncontended -> gnt during cycle after E1, rvld/r_done during cycle after E4; rerr during cycle after E2.
REQ-026 SHALL never hold more than one transaction in flight; new req during busy SHALL only set pending.
REQ-027 ram_rdaddr SHALL hold its value outside grants (no spurious address changes).
REQ-028 status_vld SHALL be sampled only at grant time; a change during ADDR/WAIT SHALL not abort the read.

Reset
REQ-029 On n_rst=0, asynchronously: state=IDLE, pending flags=0, latched addresses=0, ram_rdaddr=0, rdata=0, all gnt/rvld/rerr/r_done=0, busy=0.
REQ-030 Round-robin pointer SHALL reset to "last granted = 1" so requester 0 wins the first contended arbitration.
REQ-031 Reset mid-transaction SHALL discard the transaction with no rvld, rerr or r_done pulse after release.

Verification
REQ-032 status_vld=2'b11, ram slot1=8'hA5, req0 pulse addr0=1 -> gnt0 next-after-E1, ram_rdaddr=1, rvld0 pulse with rdata=8'hA5, r_done=2'b10, busy high 4 cycles.
REQ-033 status_vld=2'b01, req1 pulse addr1=1 -> gnt1, rerr1 pulse 2 cycles after E0, r_done=0, rdata unchanged.
REQ-034 After reset, req0 and req1 same cycle (slot0=8'h11, slot1=8'h22, addr0=0, addr1=1) -> serve 0 first (rdata=8'h11, rvld0), then 1 (rdata=8'h22, rvld1); next simultaneous pair served 0 first again only if 1 was last.
REQ-035 req0 pulsed twice during busy with addr 0 then 1 -> second pulse dropped, single follow-up read of slot 0.
REQ-036 n_rst asserted in WAIT state -> all outputs 0 immediately; after release no rvld/r_done pulse until a new req.

Source files
------------

// File: rtl/rd_port_arbiter_if.sv
// Requester-side bus of the read-port arbiter: two requesters share one
// read path; each has its own request/address/grant/valid/error strobes and
// both see the same registered read data.
interface rd_port_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 1
);
   logic                  req0;
   logic                  req1;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [ADDR_WIDTH-1:0] addr1;
   logic                  gnt0;
   logic                  gnt1;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvld0;
   logic                  rvld1;
   logic                  rerr0;
   logic                  rerr1;

   // Requester view: drives requests, receives grants and responses.
   modport master (
      output req0, req1, addr0, addr1,
      input  gnt0, gnt1, rdata, rvld0, rvld1, rerr0, rerr1
   );

   // Arbiter view.
   modport slave (
      input  req0, req1, addr0, addr1,
      output gnt0, gnt1, rdata, rvld0, rvld1, rerr0, rerr1
   );
endinterface

// File: rtl/rd_port_arbiter.sv
// Read-port arbiter: two requesters share the read port of a dual-port RAM.
// Each one-cycle request is parked in a pending flag with its slot address;
// an idle FSM grants one pending request (round-robin when both wait),
// drives the RAM address, waits out the RAM read latency and returns the
// data, or reports an error if the slot held no unread data at grant time.
// Only one read is in flight at a time.
module rd_port_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 1
) (
   input  logic                         r_clk,
   input  logic                         n_rst,
   rd_port_arbiter_if.slave             bus,
   input  logic [(1<<ADDR_WIDTH)-1:0]   status_vld,
   output logic [ADDR_WIDTH-1:0]        ram_rdaddr,
   input  logic [DATA_WIDTH-1:0]        ram_q,
   output logic [(1<<ADDR_WIDTH)-1:0]   r_done,
   output logic                         busy
);
   localparam int NSLOT = 1 << ADDR_WIDTH;
   localparam int NREQ  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WAIT,
      ST_RESP,
      ST_ERR
   } state_t;

   state_t                 state_reg;
   state_t                 state_next;

   // Requester-indexed views of the bus inputs.
   logic [NREQ-1:0]        req_vec;
   logic [ADDR_WIDTH-1:0]  req_addr [NREQ];

   // Parked requests.
   logic                   pend_reg  [NREQ];
   logic [ADDR_WIDTH-1:0]  paddr_reg [NREQ];
   logic [NREQ-1:0]        grant_clr;

   // Arbitration and transaction context.
   logic                   win;
   logic                   last_reg;
   logic                   last_next;
   logic                   owner_reg;
   logic                   owner_next;

   // Registered outputs.
   logic [ADDR_WIDTH-1:0]  rdaddr_reg;
   logic [ADDR_WIDTH-1:0]  rdaddr_next;
   logic [DATA_WIDTH-1:0]  rdata_reg;
   logic [DATA_WIDTH-1:0]  rdata_next;
   logic [NREQ-1:0]        gnt_reg;
   logic [NREQ-1:0]        gnt_next;
   logic [NREQ-1:0]        rvld_reg;
   logic [NREQ-1:0]        rvld_next;
   logic [NREQ-1:0]        rerr_reg;
   logic [NREQ-1:0]        rerr_next;
   logic [NSLOT-1:0]       r_done_reg;
   logic [NSLOT-1:0]       r_done_next;
   logic                   busy_reg;
   logic                   busy_next;

   assign req_vec     = {bus.req1, bus.req0};
   assign req_addr[0] = bus.addr0;
   assign req_addr[1] = bus.addr1;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_pend
         // Park a request; a repeat while already parked is dropped, unless
         // the parked one is being granted this very cycle, in which case the
         // new request takes its place.
         always_ff @(posedge r_clk or negedge n_rst) begin
            if (!n_rst) begin
               pend_reg[gi]  <= 1'b0;
               paddr_reg[gi] <= '0;
            end else if (req_vec[gi] && (!pend_reg[gi] || grant_clr[gi])) begin
               pend_reg[gi]  <= 1'b1;
               paddr_reg[gi] <= req_addr[gi];
            end else if (grant_clr[gi]) begin
               pend_reg[gi]  <= 1'b0;
            end
         end
      end
   endgenerate

   // FSM state register.
   always_ff @(posedge r_clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state, arbitration and next values of all registered outputs.
   always_comb begin
      state_next  = state_reg;
      win         = 1'b0;
      grant_clr   = '0;
      last_next   = last_reg;
      owner_next  = owner_reg;
      rdaddr_next = rdaddr_reg;
      rdata_next  = rdata_reg;
      gnt_next    = '0;
      rvld_next   = '0;
      rerr_next   = '0;
      r_done_next = '0;

      case (state_reg)
         ST_IDLE: begin
            if (pend_reg[0] || pend_reg[1]) begin
               // Contended: the one not served last goes; otherwise the sole
               // pending requester goes.
               if (pend_reg[0] && pend_reg[1]) begin
                  win = ~last_reg;
               end else begin
                  win = pend_reg[1];
               end
               grant_clr[win] = 1'b1;
               gnt_next[win]  = 1'b1;
               owner_next     = win;
               last_next      = win;
               rdaddr_next    = paddr_reg[win];
               // Slot status is judged once, here; later changes do not
               // affect an accepted read.
               if (status_vld[paddr_reg[win]]) begin
                  state_next = ST_ADDR;
               end else begin
                  state_next = ST_ERR;
               end
            end
         end
         ST_ADDR: begin
            // The RAM registers ram_rdaddr on this edge.
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            rdata_next = ram_q;
            state_next = ST_RESP;
         end
         ST_RESP: begin
            rvld_next[owner_reg]    = 1'b1;
            r_done_next[rdaddr_reg] = 1'b1;
            state_next              = ST_IDLE;
         end
         ST_ERR: begin
            rerr_next[owner_reg] = 1'b1;
            state_next           = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // busy spans the whole transaction as seen on the bus: from the grant
      // pulse through the final rvld/rerr pulse.
      busy_next = (state_next != ST_IDLE) || (state_reg == ST_RESP) ||
                  (state_reg == ST_ERR);
   end

   // Transaction context and registered outputs.
   always_ff @(posedge r_clk or negedge n_rst) begin
      if (!n_rst) begin
         last_reg   <= 1'b1;
         owner_reg  <= 1'b0;
         rdaddr_reg <= '0;
         rdata_reg  <= '0;
         gnt_reg    <= '0;
         rvld_reg   <= '0;
         rerr_reg   <= '0;
         r_done_reg <= '0;
         busy_reg   <= 1'b0;
      end else begin
         last_reg   <= last_next;
         owner_reg  <= owner_next;
         rdaddr_reg <= rdaddr_next;
         rdata_reg  <= rdata_next;
         gnt_reg    <= gnt_next;
         rvld_reg   <= rvld_next;
         rerr_reg   <= rerr_next;
         r_done_reg <= r_done_next;
         busy_reg   <= busy_next;
      end
   end

   assign bus.gnt0  = gnt_reg[0];
   assign bus.gnt1  = gnt_reg[1];
   assign bus.rvld0 = rvld_reg[0];
   assign bus.rvld1 = rvld_reg[1];
   assign bus.rerr0 = rerr_reg[0];
   assign bus.rerr1 = rerr_reg[1];
   assign bus.rdata = rdata_reg;
   assign ram_rdaddr = rdaddr_reg;
   assign r_done     = r_done_reg;
   assign busy       = busy_reg;
endmodule

// File: tb/tb_rd_port_arbiter.sv
// Bench for rd_port_arbiter: a synchronous-read RAM model, directed
// scenarios with cycle traces, and a scoreboard of expected grants and
// responses checked by a negedge monitor.
module tb_rd_port_arbiter;
   localparam int DW = 8;
   localparam int AW = 1;
   localparam int NS = 2;

   logic r_clk = 1'b0;
   logic n_rst = 1'b1;
   always #5 r_clk = ~r_clk;

   rd_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   logic [NS-1:0] status_vld;
   logic [NS-1:0] r_done;
   logic [AW-1:0] ram_rdaddr;
   logic [DW-1:0] ram_q;
   logic          busy;
   logic [DW-1:0] mem [NS];

   rd_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .r_clk      (r_clk),
      .n_rst      (n_rst),
      .bus        (bus),
      .status_vld (status_vld),
      .ram_rdaddr (ram_rdaddr),
      .ram_q      (ram_q),
      .r_done     (r_done),
      .busy       (busy)
   );

   // Synchronous-read RAM.
   always @(posedge r_clk) ram_q <= mem[ram_rdaddr];

   typedef struct {
      logic          who;
      logic [AW-1:0] addr;
   } gnt_t;

   typedef struct {
      logic [3:0]    kind;   // {rvld1, rvld0, rerr1, rerr0}
      logic [DW-1:0] data;
      logic [NS-1:0] done;
   } resp_t;

   gnt_t  gnt_q [$];
   resp_t resp_q [$];
   int    checks = 0;
   int    errors = 0;
   int    resp_cnt = 0;
   logic [DW-1:0] last_data = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Queue the grant and response one request should produce, in service order.
   task automatic exp_xact(input logic who, input logic [AW-1:0] slot);
      gnt_t  g;
      resp_t r;
      g.who  = who;
      g.addr = slot;
      gnt_q.push_back(g);
      r.done = '0;
      if (status_vld[slot]) begin
         r.kind       = who ? 4'b1000 : 4'b0100;
         r.data       = mem[slot];
         r.done[slot] = 1'b1;
         last_data    = mem[slot];
      end else begin
         r.kind = who ? 4'b0010 : 4'b0001;
         r.data = last_data;
      end
      resp_q.push_back(r);
   endtask

   // Called at a negedge: one-cycle request pulse, returns at the next negedge.
   task automatic pulse(input logic r0, input logic [AW-1:0] a0,
                        input logic r1, input logic [AW-1:0] a1);
      bus.req0  = r0;
      bus.addr0 = a0;
      bus.req1  = r1;
      bus.addr1 = a1;
      @(negedge r_clk);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
   endtask

   // Assert reset, check every output clears at once, then release.
   task automatic reset_check(input string tag);
      n_rst = 1'b0;
      #1;
      chk({tag, "_gnt"},    {30'd0, bus.gnt1, bus.gnt0}, 0);
      chk({tag, "_rvld"},   {30'd0, bus.rvld1, bus.rvld0}, 0);
      chk({tag, "_rerr"},   {30'd0, bus.rerr1, bus.rerr0}, 0);
      chk({tag, "_r_done"}, {30'd0, r_done}, 0);
      chk({tag, "_busy"},   {31'd0, busy}, 0);
      chk({tag, "_rdata"},  {24'd0, bus.rdata}, 0);
      chk({tag, "_rdaddr"}, {31'd0, ram_rdaddr}, 0);
      gnt_q.delete();
      resp_q.delete();
      last_data = '0;
      @(negedge r_clk);
      @(negedge r_clk);
      n_rst = 1'b1;
      @(negedge r_clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || gnt_q.size() != 0 || resp_q.size() != 0) && n < 40) begin
         @(negedge r_clk);
         n++;
      end
      if (n >= 40) chk("idle_timeout", n, 0);
      @(negedge r_clk);
   endtask

   // Samples k=0..n-1 at consecutive negedges, starting with the current one.
   task automatic trace(input int n, output logic [7:0] g0, output logic [7:0] g1,
                        output logic [7:0] bz, output logic [7:0] v0,
                        output logic [7:0] e1);
      g0 = '0; g1 = '0; bz = '0; v0 = '0; e1 = '0;
      for (int k = 0; k < n; k++) begin
         g0[k] = bus.gnt0;
         g1[k] = bus.gnt1;
         bz[k] = busy;
         v0[k] = bus.rvld0;
         e1[k] = bus.rerr1;
         @(negedge r_clk);
      end
   endtask

   // Scoreboard monitor.
   gnt_t       mon_g;
   resp_t      mon_r;
   logic [3:0] mon_kind;
   always @(negedge r_clk) begin
      if (n_rst) begin
         if (bus.gnt0 || bus.gnt1) begin
            if (gnt_q.size() == 0) begin
               chk("unexpected_gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
            end else begin
               mon_g = gnt_q.pop_front();
               chk("gnt_who", {30'd0, bus.gnt1, bus.gnt0}, mon_g.who ? 2 : 1);
               chk("gnt_rdaddr", {31'd0, ram_rdaddr}, {31'd0, mon_g.addr});
            end
         end
         mon_kind = {bus.rvld1, bus.rvld0, bus.rerr1, bus.rerr0};
         if (mon_kind != 4'b0000) begin
            resp_cnt++;
            $display("resp t=%0t kind=%b rdata=%h r_done=%b", $time, mon_kind, bus.rdata, r_done);
            if (resp_q.size() == 0) begin
               chk("unexpected_resp", {28'd0, mon_kind}, 0);
            end else begin
               mon_r = resp_q.pop_front();
               chk("resp_kind", {28'd0, mon_kind}, {28'd0, mon_r.kind});
               chk("resp_rdata", {24'd0, bus.rdata}, {24'd0, mon_r.data});
               chk("resp_r_done", {30'd0, r_done}, {30'd0, mon_r.done});
            end
         end else if (r_done != '0) begin
            chk("stray_r_done", {30'd0, r_done}, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   logic [7:0] tg0, tg1, tbz, tv0, te1;
   int         snap;

   initial begin
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.addr0 = '0;  bus.addr1 = '0;
      status_vld = 2'b11;
      mem[0] = 8'h11;
      mem[1] = 8'hA5;
      @(negedge r_clk);
      reset_check("rst0");

      // Uncontended read of slot 1.
      status_vld = 2'b11;
      exp_xact(1'b0, 1'b1);
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      trace(6, tg0, tg1, tbz, tv0, te1);
      chk("rd_gnt0_trace", {24'd0, tg0}, 32'h02);
      chk("rd_busy_trace", {24'd0, tbz}, 32'h1E);
      chk("rd_rvld0_trace", {24'd0, tv0}, 32'h10);
      wait_idle();

      // Empty slot: error, rdata kept.
      status_vld = 2'b01;
      exp_xact(1'b1, 1'b1);
      pulse(1'b0, 1'b0, 1'b1, 1'b1);
      trace(6, tg0, tg1, tbz, tv0, te1);
      chk("err_gnt1_trace", {24'd0, tg1}, 32'h02);
      chk("err_rerr1_trace", {24'd0, te1}, 32'h04);
      chk("err_busy_trace", {24'd0, tbz}, 32'h06);
      wait_idle();

      // Round-robin after reset.
      reset_check("rst1");
      status_vld = 2'b11;
      mem[0] = 8'h11;
      mem[1] = 8'h22;
      exp_xact(1'b0, 1'b0);
      exp_xact(1'b1, 1'b1);
      pulse(1'b1, 1'b0, 1'b1, 1'b1);
      wait_idle();
      exp_xact(1'b0, 1'b0);
      exp_xact(1'b1, 1'b1);
      pulse(1'b1, 1'b0, 1'b1, 1'b1);
      wait_idle();
      exp_xact(1'b0, 1'b1);
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      wait_idle();
      exp_xact(1'b1, 1'b1);
      exp_xact(1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b1, 1'b1);
      wait_idle();

      // New request on the same edge its parked one is granted.
      exp_xact(1'b1, 1'b0);
      exp_xact(1'b1, 1'b1);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b0, 1'b1, 1'b1);
      wait_idle();

      // Two requests while busy: second dropped.
      snap = resp_cnt;
      exp_xact(1'b0, 1'b1);
      exp_xact(1'b0, 1'b0);
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge r_clk);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      wait_idle();
      repeat (6) @(negedge r_clk);
      chk("drop_resp_count", resp_cnt - snap, 2);

      // Status falls after grant: the read still completes.
      exp_xact(1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge r_clk);
      status_vld = 2'b00;
      wait_idle();
      status_vld = 2'b11;

      // Reset while waiting on the RAM.
      exp_xact(1'b0, 1'b1);
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge r_clk);
      @(negedge r_clk);
      chk("mid_busy", {31'd0, busy}, 1);
      reset_check("rst_wait");
      snap = resp_cnt;
      repeat (8) @(negedge r_clk);
      chk("post_rst_resp", resp_cnt - snap, 0);

      // Random single-requester traffic.
      for (int i = 0; i < 10; i++) begin
         logic          who;
         logic [AW-1:0] slot;
         who        = 1'($urandom_range(0, 1));
         slot       = AW'($urandom_range(0, NS - 1));
         status_vld = NS'($urandom_range(0, 3));
         mem[slot]  = DW'($urandom_range(0, 255));
         exp_xact(who, slot);
         if (who) pulse(1'b0, 1'b0, 1'b1, slot);
         else     pulse(1'b1, slot, 1'b0, 1'b0);
         wait_idle();
      end

      chk("gnt_q_empty", gnt_q.size(), 0);
      chk("resp_q_empty", resp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
